sseg_capture: RTL

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_capture.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/sseg_capture.sv
// sseg_capture: recovers the number shown on a multiplexed 4-digit
// seven-segment display by watching its anode and cathode lines.
// Each digit is captured after its anode/cathode pair has been stable for
// STABLE_CYCLES cycles. A frame is published once all four digit slots
// have been captured.
// Optional feature macro: SSEG_CAPTURE_BIN_EN adds the BCD-to-binary
// conversion that drives 'value'. Without it, 'value' is tied to zero.
module sseg_capture #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic        clock_100Mhz,
    input  logic        reset_n,
    input  logic [3:0]  Anode_Activate,
    input  logic [6:0]  LED_out,
    output logic [15:0] digits,
    output logic [13:0] value,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    // The transition fires on the cycle the counter would step to STABLE_CYCLES-1,
    // so a digit held exactly STABLE_CYCLES cycles is captured.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [3:0]       an_s1_q, an_s2_q;
    logic [6:0]       seg_s1_q, seg_s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       an_hold_q;
    logic [6:0]       seg_hold_q;
    logic [15:0]      slots_q;
    logic [3:0]       mask_q;
    logic [3:0]       err_q;
    logic [15:0]      stage_q;
    logic             stage_err_q;
    logic             load_q;

    logic             an_valid_c;
    logic             changed_c;
    logic             capture_c;
    logic             frame_load_c;
    logic [1:0]       slot_idx_c;
    logic [3:0]       nib_c;
    logic [13:0]      value_c;

    // Two-flop synchronizers on the observed display lines
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            an_s1_q  <= '0;
            an_s2_q  <= '0;
            seg_s1_q <= '0;
            seg_s2_q <= '0;
        end else begin
            an_s1_q  <= Anode_Activate;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= LED_out;
            seg_s2_q <= seg_s1_q;
        end
    end

    // Anode qualification, change detection and capture strobe
    always_comb begin
        an_valid_c = (an_s2_q == 4'b0111) || (an_s2_q == 4'b1011) ||
                     (an_s2_q == 4'b1101) || (an_s2_q == 4'b1110);
        changed_c  = (an_s2_q != an_hold_q) || (seg_s2_q != seg_hold_q);
        capture_c  = (state_q == DWELL) && an_valid_c && !changed_c && (cnt_q == CNT_LAST);
        frame_load_c = &mask_q;
    end

    // Slot index (3 = most significant digit) and cathode decode of the held pattern
    always_comb begin
        unique case (an_hold_q)
            4'b0111: slot_idx_c = 2'd3;
            4'b1011: slot_idx_c = 2'd2;
            4'b1101: slot_idx_c = 2'd1;
            default: slot_idx_c = 2'd0;
        endcase
        case (seg_hold_q)
            7'b0000001: nib_c = 4'd0;
            7'b1001111: nib_c = 4'd1;
            7'b0010010: nib_c = 4'd2;
            7'b0000110: nib_c = 4'd3;
            7'b1001100: nib_c = 4'd4;
            7'b0100100: nib_c = 4'd5;
            7'b0100000: nib_c = 4'd6;
            7'b0001111: nib_c = 4'd7;
            7'b0000000: nib_c = 4'd8;
            7'b0000100: nib_c = 4'd9;
            default:    nib_c = 4'hF;
        endcase
    end

    // Digit tracking FSM: seek a valid anode, dwell until stable, then hold
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEEK;
            cnt_q      <= '0;
            an_hold_q  <= '0;
            seg_hold_q <= '0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (an_valid_c) begin
                        state_q    <= DWELL;
                        cnt_q      <= '0;
                        an_hold_q  <= an_s2_q;
                        seg_hold_q <= seg_s2_q;
                    end
                end
                DWELL: begin
                    if (!an_valid_c) begin
                        state_q <= SEEK;
                    end else if (changed_c) begin
                        cnt_q      <= '0;
                        an_hold_q  <= an_s2_q;
                        seg_hold_q <= seg_s2_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!an_valid_c) begin
                        state_q <= SEEK;
                    end else if (changed_c) begin
                        state_q    <= DWELL;
                        cnt_q      <= '0;
                        an_hold_q  <= an_s2_q;
                        seg_hold_q <= seg_s2_q;
                    end
                end
                default: state_q <= SEEK;
            endcase
        end
    end

    // Slot storage; a capture coinciding with a frame load seeds the next frame
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            slots_q <= '0;
            mask_q  <= '0;
            err_q   <= '0;
        end else begin
            if (frame_load_c) begin
                mask_q <= '0;
                err_q  <= '0;
            end
            if (capture_c) begin
                slots_q[{slot_idx_c, 2'b00} +: 4] <= nib_c;
                mask_q[slot_idx_c]                <= 1'b1;
                err_q[slot_idx_c]                 <= (nib_c == 4'hF);
            end
        end
    end

    // Frame staging register gives the binary conversion a full cycle
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            stage_q     <= '0;
            stage_err_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            load_q <= frame_load_c;
            if (frame_load_c) begin
                stage_q     <= slots_q;
                stage_err_q <= |err_q;
            end
        end
    end

`ifdef SSEG_CAPTURE_BIN_EN
    // BCD to binary; any unrecognized digit forces zero
    always_comb begin
        value_c = 14'(stage_q[15:12]) * 14'd1000 +
                  14'(stage_q[11:8])  * 14'd100  +
                  14'(stage_q[7:4])   * 14'd10   +
                  14'(stage_q[3:0]);
        if ((stage_q[15:12] == 4'hF) || (stage_q[11:8] == 4'hF) ||
            (stage_q[7:4] == 4'hF) || (stage_q[3:0] == 4'hF)) begin
            value_c = '0;
        end
    end
`else
    // Binary path not built
    assign value_c = '0;
`endif

    // Published frame outputs, held between frames
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            digits      <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= load_q;
            if (load_q) begin
                digits    <= stage_q;
                value     <= value_c;
                frame_err <= stage_err_q;
            end
        end
    end

endmodule
